cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the 8-bit, 4-register processor datapath (PC, IR, register file, 32-byte data memory).
- Sequences fetch, decode, memory access and write-back using request/acknowledge handshakes to the instruction and data memories.
- Supports free-run and single-step execution.
- Emits the enable and select strobes the datapath consumes, plus a sticky fault on memory timeout.

Parameters:
- TIMEOUT, 15, max cycles a request (imem_req or dmem_req) may wait for its ack before FAULT.
- CNT_W, 4, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- run  in  1  level; 1 = execute instructions back-to-back.
- step  in  1  one-cycle pulse; executes one instruction when sampled in HALT.
- instruction  in  8  instruction byte, valid when imem_ack=1.
- imem_ack  in  1  instruction memory acknowledge.
- dmem_ack  in  1  data memory acknowledge.
- imem_req  out  1  instruction fetch request.
- ir  out  8  latched instruction register.
- rf_raddr_a  out  2  read port A = ir[5:4] (ADD source / LD-ST base).
- rf_raddr_b  out  2  read port B = ir[3:2] (ADD source / ST data).
- rf_we  out  1  register write strobe, one cycle.
- rf_waddr  out  2  write index: ir[1:0] for ADD, ir[3:2] for LD.
- wb_sel  out  1  0 = ALU sum, 1 = data memory read data.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store, valid with dmem_req.
- pc_en  out  1  one-cycle strobe; datapath does pc <= pc + 1 + pc_offset.
- pc_offset  out  8  sign-extended ir[1:0] for JMP, 8'd0 otherwise.
- state  out  3  current state encoding, for debug LEDs.
- busy  out  1  1 in every state except HALT and FAULT.
- fault  out  1  sticky; 1 in FAULT.

Behaviour:
- Opcode = ir[7:6]: 00 ADD, 01 LD, 10 ST, 11 JMP. Immediate = {7{ir[1]}, ir[0]}.
- States: HALT, FETCH, DECODE, MEM, WB, FAULT.
- Reset (reset=0 at a clock edge, any state):
  - state=HALT; ir=0; watchdog=0; fault=0.
  - All strobes and requests 0; an outstanding request is abandoned.
- HALT:
  - run=1 or step=1 -> FETCH.
  - Both asserted behaves as run.
  - step is ignored in every other state; no queuing.
- FETCH:
  - imem_req=1 held until imem_ack.
  - On ack: ir <= instruction, go DECODE.
  - Ack in the same cycle as the request is legal (zero wait).
- DECODE: one cycle. Next state MEM for LD/ST, WB for ADD/JMP.
- MEM:
  - dmem_req=1, dmem_we=(op==ST), held until dmem_ack, then -> WB.
  - Address = reg[ir[5:4]] + imm is computed by the datapath, not here.
- WB (exactly one cycle):
  - pc_en=1.
  - rf_we=1 for ADD/LD, 0 for ST/JMP.
  - wb_sel=1 only for LD.
  - Next: FETCH if run=1, else HALT.
  - run dropping mid-instruction completes that instruction, then HALT.
- Watchdog:
  - Clears on entry to FETCH/MEM; increments each cycle a request is pending without ack.
  - Reaching TIMEOUT -> FAULT.
  - Ack in the same cycle the count reaches TIMEOUT wins (no fault).
- FAULT: all strobes 0, fault=1, busy=0. Exit only via reset.
- Stray acks (ack outside FETCH/MEM, or imem_ack in MEM) are ignored.
- ir, rf_* and pc_offset are stable from DECODE through WB.
- Zero-wait latency: ADD/JMP = 3 cycles (FETCH, DECODE, WB); LD/ST = 4 cycles.
- pc_offset width: 8-bit two's complement; pc wrap 255 -> 0 is the datapath's concern.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_ADD, OP_LD, OP_ST, OP_JMP;
  - state enum (3-bit encoding exported on the state port);
  - immediate sign-extension function, reused by the datapath.
- One sub-module, ack_watchdog: clear/enable/count with a timeout flag, instantiated once and shared by FETCH and MEM.

Test Plan:
1. run=1, zero-wait acks, instruction=8'b00_01_10_11 (ADD) -> FETCH, DECODE, WB; at WB rf_we=1, rf_waddr=3, rf_raddr_a=1, rf_raddr_b=2, wb_sel=0, pc_en=1; next cycle FETCH.
2. run=0, step pulse, LD 8'b01_10_01_11 with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0; WB has rf_we=1, rf_waddr=1, wb_sel=1; then HALT, busy=0.
3. ST 8'b10_00_11_01 -> dmem_we=1 during MEM; WB has rf_we=0, pc_en=1. JMP 8'b11_000010 -> pc_offset=8'hFE at WB; JMP 8'b11_000001 -> pc_offset=8'h01.
4. imem_ack held low, TIMEOUT=15 -> FAULT after 15 pending cycles, fault=1, imem_req=0; run/step ignored. Ack on exactly the 15th cycle -> DECODE, no fault.
5. reset=0 asserted during MEM with dmem_req=1 -> next edge state=HALT, all outputs 0, ir=0; a late dmem_ack afterwards is ignored.
6. run dropped during DECODE of ADD -> WB completes (pc_en=1, rf_we=1), then HALT; step pulse during FETCH has no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the 8-bit, 4-register processor: opcode values,
// the sequencer state encoding (exported on the debug state port) and the
// immediate sign-extension helper used by both the sequencer and datapath.
package cpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LD  = 2'b01;
    localparam logic [1:0] OP_ST  = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    // Two-bit immediate ir[1:0] widened to an 8-bit two's complement value.
    function automatic logic [7:0] sext_imm(input logic [1:0] imm);
        return {{6{imm[1]}}, imm};
    endfunction

endpackage

// File: rtl/ack_watchdog.sv
// ack_watchdog
// Counts cycles that a memory request has been waiting for its acknowledge.
// Ports:
//   clock   - system clock
//   reset   - synchronous active-low reset
//   clear   - forces the count to zero (held while no request phase is active)
//   enable  - a request is pending and has not been acknowledged this cycle
//   timeout - this pending cycle is the TIMEOUT-th one without an ack
module ack_watchdog #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // An ack in the same cycle keeps enable low, so the ack always wins
    // against a timeout that would otherwise fire in that cycle.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    assign timeout = enable && !clear && (count_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Multi-cycle control FSM: HALT -> FETCH -> DECODE -> (MEM) -> WB, with a
// watchdog on both memory handshakes and a sticky FAULT state.
// Ports:
//   clock, reset (sync, active-low)
//   run, step            - free-run level / single-step pulse
//   instruction, imem_ack, imem_req - instruction memory handshake
//   dmem_ack, dmem_req, dmem_we     - data memory handshake
//   ir, rf_raddr_a/b, rf_we, rf_waddr, wb_sel, pc_en, pc_offset - datapath control
//   state, busy, fault   - status
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       step,
    input  logic [7:0] instruction,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic [7:0] ir,
    output logic [1:0] rf_raddr_a,
    output logic [1:0] rf_raddr_b,
    output logic       rf_we,
    output logic [1:0] rf_waddr,
    output logic       wb_sel,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       pc_en,
    output logic [7:0] pc_offset,
    output logic [2:0] state,
    output logic       busy,
    output logic       fault
);

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic       imem_req_q, imem_req_d;
    logic       dmem_req_q, dmem_req_d;
    logic       dmem_we_q, dmem_we_d;
    logic       rf_we_q, rf_we_d;
    logic       wb_sel_q, wb_sel_d;
    logic       pc_en_q, pc_en_d;
    logic       busy_q, busy_d;
    logic       fault_q, fault_d;

    logic       wd_clear;
    logic       wd_enable;
    logic       wd_timeout;
    logic [1:0] op_q;
    logic [1:0] op_d;

    assign op_q = ir_q[7:6];
    assign op_d = ir_d[7:6];

    // One counter serves both request phases; it is held at zero outside
    // them so every entry into FETCH or MEM starts from a clean count.
    assign wd_clear  = !((state_q == S_FETCH) || (state_q == S_MEM));
    assign wd_enable = ((state_q == S_FETCH) && !imem_ack) ||
                       ((state_q == S_MEM)   && !dmem_ack);

    ack_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .timeout (wd_timeout)
    );

    // Next-state logic. Strobes are decoded from the next state so that
    // they are registered yet line up exactly with the state they belong to.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            S_HALT: begin
                if (run || step) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = instruction;
                    state_d = S_DECODE;
                end else if (wd_timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                state_d = ((op_q == OP_LD) || (op_q == OP_ST)) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = S_WB;
                end else if (wd_timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_WB: begin
                state_d = run ? S_FETCH : S_HALT;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        imem_req_d = (state_d == S_FETCH);
        dmem_req_d = (state_d == S_MEM);
        dmem_we_d  = (state_d == S_MEM) && (op_d == OP_ST);
        pc_en_d    = (state_d == S_WB);
        rf_we_d    = (state_d == S_WB) && ((op_d == OP_ADD) || (op_d == OP_LD));
        wb_sel_d   = (state_d == S_WB) && (op_d == OP_LD);
        busy_d     = (state_d != S_HALT) && (state_d != S_FAULT);
        fault_d    = (state_d == S_FAULT);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_HALT;
            ir_q       <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            wb_sel_q   <= 1'b0;
            pc_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            rf_we_q    <= rf_we_d;
            wb_sel_q   <= wb_sel_d;
            pc_en_q    <= pc_en_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
        end
    end

    // Register-file indices come straight from the latched instruction,
    // so they are stable from DECODE through WB.
    assign rf_raddr_a = ir_q[5:4];
    assign rf_raddr_b = ir_q[3:2];
    assign rf_waddr   = (op_q == OP_LD) ? ir_q[3:2] : ir_q[1:0];
    assign pc_offset  = (op_q == OP_JMP) ? sext_imm(ir_q[1:0]) : 8'd0;

    assign ir       = ir_q;
    assign imem_req = imem_req_q;
    assign dmem_req = dmem_req_q;
    assign dmem_we  = dmem_we_q;
    assign rf_we    = rf_we_q;
    assign wb_sel   = wb_sel_q;
    assign pc_en    = pc_en_q;
    assign state    = state_q;
    assign busy     = busy_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
// Self-checking bench for cpu_sequencer: a table of single-stepped
// instructions whose write-back expectations go through a scoreboard queue,
// plus hand-written sequences for free-run, timeout, and reset corner cases.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       run;
    logic       step;
    logic [7:0] instruction;
    logic       imem_ack;
    logic       dmem_ack;
    logic       imem_req;
    logic [7:0] ir;
    logic [1:0] rf_raddr_a;
    logic [1:0] rf_raddr_b;
    logic       rf_we;
    logic [1:0] rf_waddr;
    logic       wb_sel;
    logic       dmem_req;
    logic       dmem_we;
    logic       pc_en;
    logic [7:0] pc_offset;
    logic [2:0] state;
    logic       busy;
    logic       fault;

    int checksTotal  = 0;
    int checksPassed = 0;

    typedef struct {
        logic [7:0] instr;
        int         imemWait;
        int         dmemWait;
        bit         isMem;
        bit         expDmemWe;
        bit         expRfWe;
        bit         chkWaddr;
        logic [1:0] expWaddr;
        logic [1:0] expRa;
        logic [1:0] expRb;
        bit         expWbSel;
        logic [7:0] expOffset;
    } vec_t;

    typedef struct {
        bit         rfWe;
        bit         chkWaddr;
        logic [1:0] waddr;
        logic [1:0] ra;
        logic [1:0] rb;
        bit         wbSel;
        logic [7:0] offset;
    } wb_t;

    wb_t  scoreboard[$];
    vec_t vecs[7];

    cpu_sequencer #(.TIMEOUT(15), .CNT_W(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .instruction (instruction),
        .imem_ack    (imem_ack),
        .dmem_ack    (dmem_ack),
        .imem_req    (imem_req),
        .ir          (ir),
        .rf_raddr_a  (rf_raddr_a),
        .rf_raddr_b  (rf_raddr_b),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .wb_sel      (wb_sel),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .pc_en       (pc_en),
        .pc_offset   (pc_offset),
        .state       (state),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 clock = ~clock;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Single-step one instruction from HALT and compare every phase.
    task automatic applyStimulus(input vec_t v);
        wb_t exp;
        wb_t got;
        int  reqCycles;
        exp.rfWe     = v.expRfWe;
        exp.chkWaddr = v.chkWaddr;
        exp.waddr    = v.expWaddr;
        exp.ra       = v.expRa;
        exp.rb       = v.expRb;
        exp.wbSel    = v.expWbSel;
        exp.offset   = v.expOffset;
        scoreboard.push_back(exp);

        step = 1'b1;
        tick();
        step = 1'b0;
        checkOutput("fetch_state", 32'(state), 32'(S_FETCH));
        checkOutput("fetch_req", 32'(imem_req), 32'd1);
        repeat (v.imemWait) tick();
        checkOutput("fetch_wait_req", 32'(imem_req), 32'd1);
        instruction = v.instr;
        imem_ack    = 1'b1;
        tick();
        imem_ack    = 1'b0;
        instruction = 8'hA5;
        checkOutput("decode_state", 32'(state), 32'(S_DECODE));
        checkOutput("decode_ir", 32'(ir), 32'(v.instr));
        tick();
        if (v.isMem) begin
            reqCycles = 0;
            checkOutput("mem_state", 32'(state), 32'(S_MEM));
            repeat (v.dmemWait) begin
                if (dmem_req) reqCycles++;
                checkOutput("mem_dmem_we", 32'(dmem_we), 32'(v.expDmemWe));
                tick();
            end
            if (dmem_req) reqCycles++;
            checkOutput("mem_dmem_we", 32'(dmem_we), 32'(v.expDmemWe));
            dmem_ack = 1'b1;
            tick();
            dmem_ack = 1'b0;
            checkOutput("dmem_req_cycles", 32'(reqCycles), 32'(v.dmemWait + 1));
        end
        checkOutput("wb_state", 32'(state), 32'(S_WB));
        checkOutput("wb_pc_en", 32'(pc_en), 32'd1);
        checkOutput("wb_dmem_req", 32'(dmem_req), 32'd0);
        checkOutput("wb_scoreboard_nonempty", 32'(scoreboard.size() > 0), 32'd1);
        if (scoreboard.size() > 0) begin
            got = scoreboard.pop_front();
            checkOutput("wb_rf_we", 32'(rf_we), 32'(got.rfWe));
            if (got.chkWaddr) checkOutput("wb_rf_waddr", 32'(rf_waddr), 32'(got.waddr));
            checkOutput("wb_raddr_a", 32'(rf_raddr_a), 32'(got.ra));
            checkOutput("wb_raddr_b", 32'(rf_raddr_b), 32'(got.rb));
            checkOutput("wb_sel", 32'(wb_sel), 32'(got.wbSel));
            checkOutput("wb_pc_offset", 32'(pc_offset), 32'(got.offset));
        end
        tick();
        checkOutput("halt_state", 32'(state), 32'(S_HALT));
        checkOutput("halt_busy", 32'(busy), 32'd0);
        checkOutput("halt_pc_en", 32'(pc_en), 32'd0);
    endtask

    initial begin
        int cycles;

        // instr, imemWait, dmemWait, isMem, dmemWe, rfWe, chkWaddr, waddr, ra, rb, wbSel, offset
        vecs[0] = '{8'h1B, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00};
        vecs[1] = '{8'h67, 0, 3, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 2'd2, 2'd1, 1'b1, 8'h00};
        vecs[2] = '{8'h8D, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd3, 1'b0, 8'h00};
        vecs[3] = '{8'hC2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 8'hFE};
        vecs[4] = '{8'hC1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h01};
        vecs[5] = '{8'h32, 2, 0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 2'd3, 2'd0, 1'b0, 8'h00};
        vecs[6] = '{8'h48, 0, 1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 2'd0, 2'd2, 1'b1, 8'h00};

        reset       = 1'b0;
        run         = 1'b0;
        step        = 1'b0;
        instruction = 8'h00;
        imem_ack    = 1'b0;
        dmem_ack    = 1'b0;
        repeat (2) tick();
        checkOutput("rst_state", 32'(state), 32'(S_HALT));
        checkOutput("rst_ir", 32'(ir), 32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
        reset = 1'b1;
        tick();
        checkOutput("idle_state", 32'(state), 32'(S_HALT));

        // Free-run ADD with zero-wait acks, back-to-back into the next fetch.
        run = 1'b1;
        tick();
        checkOutput("run_fetch", 32'(state), 32'(S_FETCH));
        instruction = 8'h1B;
        imem_ack    = 1'b1;
        tick();
        imem_ack = 1'b0;
        checkOutput("run_decode", 32'(state), 32'(S_DECODE));
        tick();
        checkOutput("run_wb_state", 32'(state), 32'(S_WB));
        checkOutput("run_wb_rf_we", 32'(rf_we), 32'd1);
        checkOutput("run_wb_waddr", 32'(rf_waddr), 32'd3);
        checkOutput("run_wb_ra", 32'(rf_raddr_a), 32'd1);
        checkOutput("run_wb_rb", 32'(rf_raddr_b), 32'd2);
        checkOutput("run_wb_sel", 32'(wb_sel), 32'd0);
        checkOutput("run_wb_pc_en", 32'(pc_en), 32'd1);
        tick();
        checkOutput("run_refetch", 32'(state), 32'(S_FETCH));
        checkOutput("run_refetch_pc_en", 32'(pc_en), 32'd0);
        // A step pulse while fetching must not disturb anything.
        step = 1'b1;
        tick();
        step = 1'b0;
        checkOutput("step_in_fetch", 32'(state), 32'(S_FETCH));
        instruction = 8'h1B;
        imem_ack    = 1'b1;
        tick();
        imem_ack = 1'b0;
        run      = 1'b0;
        checkOutput("drop_decode", 32'(state), 32'(S_DECODE));
        tick();
        checkOutput("drop_wb_pc_en", 32'(pc_en), 32'd1);
        checkOutput("drop_wb_rf_we", 32'(rf_we), 32'd1);
        tick();
        checkOutput("drop_halt", 32'(state), 32'(S_HALT));
        checkOutput("drop_busy", 32'(busy), 32'd0);
        tick();
        checkOutput("no_queued_step", 32'(state), 32'(S_HALT));

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
        end
        checkOutput("scoreboard_empty", 32'(scoreboard.size()), 32'd0);

        // Instruction memory never answers: FAULT after 15 pending cycles.
        step = 1'b1;
        tick();
        step   = 1'b0;
        cycles = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (state != 3'(S_FETCH)) break;
            cycles++;
        end
        checkOutput("timeout_cycles", 32'(cycles), 32'd15);
        checkOutput("timeout_state", 32'(state), 32'(S_FAULT));
        checkOutput("timeout_fault", 32'(fault), 32'd1);
        checkOutput("timeout_imem_req", 32'(imem_req), 32'd0);
        checkOutput("timeout_busy", 32'(busy), 32'd0);
        run  = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (3) tick();
        checkOutput("fault_sticky_state", 32'(state), 32'(S_FAULT));
        checkOutput("fault_sticky", 32'(fault), 32'd1);
        run   = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkOutput("fault_reset_state", 32'(state), 32'(S_HALT));
        checkOutput("fault_reset_fault", 32'(fault), 32'd0);

        // Ack on exactly the 15th pending cycle beats the watchdog.
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (14) tick();
        checkOutput("late_ack_still_fetch", 32'(state), 32'(S_FETCH));
        instruction = 8'h1B;
        imem_ack    = 1'b1;
        tick();
        imem_ack = 1'b0;
        checkOutput("late_ack_decode", 32'(state), 32'(S_DECODE));
        checkOutput("late_ack_no_fault", 32'(fault), 32'd0);
        repeat (2) tick();
        checkOutput("late_ack_halt", 32'(state), 32'(S_HALT));

        // Reset while a data request is outstanding abandons it.
        step = 1'b1;
        tick();
        step        = 1'b0;
        instruction = 8'h67;
        imem_ack    = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        checkOutput("rstmem_req", 32'(dmem_req), 32'd1);
        reset = 1'b0;
        tick();
        checkOutput("rstmem_state", 32'(state), 32'(S_HALT));
        checkOutput("rstmem_dmem_req", 32'(dmem_req), 32'd0);
        checkOutput("rstmem_ir", 32'(ir), 32'd0);
        checkOutput("rstmem_busy", 32'(busy), 32'd0);
        checkOutput("rstmem_rf_we", 32'(rf_we), 32'd0);
        reset    = 1'b1;
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        checkOutput("stray_ack_state", 32'(state), 32'(S_HALT));
        checkOutput("stray_ack_pc_en", 32'(pc_en), 32'd0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
